clk_step_ctrl: RTL and testbench
================================

Name: clk_step_ctrl

Overview:
- Processor clock controller between the board clock and the RISC-V core; replaces the fixed divide-by-2 clock source.
- Generates a single-cycle clock-enable pulse (cpu_ce) for the core. The core stays on the board clock and qualifies its state updates with cpu_ce.
- Two modes: free-run at a programmable divide ratio, and single-step driven by a debounced push-button.

Parameters:
- DIV_W, 8, width of the div_ratio input.
- DB_CYCLES, 16, number of consecutive stable synchronized samples needed before the debounced button level changes (minimum 2).
- CNT_W, 16, width of the step_count output.

Ports:
- clk  input  1  board clock; the only clock.
- rst  input  1  asynchronous, active-low reset.
- run_mode  input  1  1 = free-run, 0 = halt/single-step. Asynchronous (board switch).
- step_btn  input  1  raw step push-button, active-high. Asynchronous and bouncy.
- div_ratio  input  DIV_W  free-run period minus one, in clk cycles.
- cpu_ce  output  1  registered one-cycle clock-enable pulse to the core.
- halted  output  1  registered; 1 while the FSM is in HALT.
- step_count  output  CNT_W  registered count of cpu_ce pulses issued.

Behaviour:
- Reset (rst=0), asynchronous:
  - state=HALT, cpu_ce=0, halted=1, step_count=0.
  - Synchronizers, debounce counter, debounced level (db_lvl), its delayed copy and div counter all go to 0.
- Synchronizers:
  - run_mode and step_btn each pass through a 2-flop synchronizer, giving run_s and btn_s.
- Debouncer:
  - If btn_s == db_lvl: db_cnt clears to 0.
  - Otherwise db_cnt increments. When btn_s still differs and db_cnt == DB_CYCLES-1, db_lvl takes btn_s and db_cnt clears.
  - Any mismatch-free cycle restarts the count, so a glitch shorter than DB_CYCLES cycles never reaches db_lvl.
- Step request: step_req = db_lvl & ~db_lvl_d, where db_lvl_d is db_lvl delayed one cycle. It is high for exactly one cycle per debounced press.
- FSM states: HALT, RUN, STEP_WAIT.
  - HALT, run_s=1: go to RUN with div_cnt=0. run_s takes priority over step_req.
  - HALT, run_s=0 and step_req=1: cpu_ce<=1 for one cycle, go to STEP_WAIT.
  - STEP_WAIT: stay until db_lvl=0, then go to HALT. Presses held or repeated in this state produce no extra pulses.
  - STEP_WAIT, run_s=1: go to RUN directly.
  - RUN, run_s=0: go to HALT, div_cnt<=0, no pulse issued on that cycle.
  - RUN ignores step_req.
- Divider (RUN only):
  - If div_cnt >= div_ratio: cpu_ce<=1 and div_cnt<=0. Otherwise cpu_ce<=0 and div_cnt<=div_cnt+1.
  - Pulse period is div_ratio+1 cycles.
  - div_ratio=0 gives cpu_ce high every cycle.
  - If div_ratio is lowered below the current div_cnt mid-count, a pulse fires on the next cycle (>= compare), never a long wraparound.
- halted is registered from the next-state value, so it equals 1 exactly when state==HALT.
- step_count increments on every cycle where cpu_ce=1 and wraps from all-ones to 0.
- Latency:
  - Step: debounced db_lvl rise at edge N gives step_req during cycle N, and cpu_ce=1 during cycle N+1.
  - Raw press to pulse: 2 + DB_CYCLES + 1 cycles, given a clean input.
  - Run: the first pulse follows div_ratio+1 cycles after RUN is entered.
- Reset asserted mid-operation aborts any pending pulse immediately. After reset release the FSM is in HALT; a button still held at release is treated as a new press once debounced.

Optional Feature:
- Macro: CLK_STEP_CLKOUT_EN.
- Defined: adds output port cpu_clk (1 bit, registered, reset 0). It toggles on every cycle where cpu_ce=1, giving a visible square-wave clock for LEDs or the logic analyzer with period 2*(div_ratio+1) in RUN.
- Undefined: the cpu_clk port and its flop do not exist; all other behaviour is identical.

Test Plan (bench uses DB_CYCLES=4, DIV_W=8):
- Reset hold: rst=0, toggle all inputs → cpu_ce=0, halted=1, step_count=0 throughout.
- Free-run: run_mode=1, div_ratio=3 → after sync, cpu_ce pulses every 4 cycles. div_ratio=0 → cpu_ce=1 every cycle. 10 pulses → step_count=10.
- Ratio shrink: div_ratio=200, at div_cnt≈100 set div_ratio=5 → pulse on the next cycle, then every 6 cycles.
- Bounce rejection: run_mode=0, step_btn high for 3 cycles then low, repeated ×5 → no cpu_ce. Clean press held 40 cycles → exactly one cpu_ce, 7 cycles after the rise; step_count=1.
- Mode switch: run_mode 1→0 mid-count → halted=1 within 3 cycles, no further pulses. Press while in RUN → no extra pulse.
- Mid-operation reset: rst=0 during RUN with div_ratio=2 → cpu_ce drops asynchronously. After release: halted=1, step_count=0. With CLK_STEP_CLKOUT_EN defined, cpu_clk=0.

Source files
------------

// File: rtl/clk_step_ctrl.sv
// Core clock-enable generator: free-run divider or debounced single-step.
// Optional CLK_STEP_CLKOUT_EN adds a visible cpu_clk square wave output.
module clk_step_ctrl #(
    parameter int DIV_W     = 8,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_mode,
    input  logic             step_btn,
    input  logic [DIV_W-1:0] div_ratio,
    output logic             cpu_ce,
    output logic             halted,
    output logic [CNT_W-1:0] step_count
`ifdef CLK_STEP_CLKOUT_EN
    ,
    output logic             cpu_clk
`endif
);

    localparam int DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        HALT      = 2'd0,
        RUN       = 2'd1,
        STEP_WAIT = 2'd2
    } state_t;

    logic [1:0] async_in;
    logic [1:0] sync_out;
    logic       run_s;
    logic       btn_s;

    assign async_in = {step_btn, run_mode};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= async_in[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign sync_out[gi] = s2_reg;
        end
    endgenerate

    assign run_s = sync_out[0];
    assign btn_s = sync_out[1];

    logic [DB_W-1:0] db_cnt_reg;
    logic            db_lvl_reg;
    logic            db_lvl_d_reg;
    logic            step_req;

    // The level only moves after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt_reg   <= '0;
            db_lvl_reg   <= 1'b0;
            db_lvl_d_reg <= 1'b0;
        end else begin
            db_lvl_d_reg <= db_lvl_reg;
            if (btn_s == db_lvl_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
                db_lvl_reg <= btn_s;
                db_cnt_reg <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

    assign step_req = db_lvl_reg & ~db_lvl_d_reg;

    state_t           state_reg, state_next;
    logic             cpu_ce_reg, cpu_ce_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic             halted_reg;
    logic [CNT_W-1:0] step_count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= HALT;
            cpu_ce_reg     <= 1'b0;
            div_cnt_reg    <= '0;
            halted_reg     <= 1'b1;
            step_count_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cpu_ce_reg  <= cpu_ce_next;
            div_cnt_reg <= div_cnt_next;
            halted_reg  <= (state_next == HALT);
            if (cpu_ce_reg) begin
                step_count_reg <= step_count_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        cpu_ce_next  = 1'b0;
        div_cnt_next = div_cnt_reg;
        case (state_reg)
            HALT: begin
                if (run_s) begin
                    state_next   = RUN;
                    div_cnt_next = '0;
                end else if (step_req) begin
                    cpu_ce_next = 1'b1;
                    state_next  = STEP_WAIT;
                end
            end
            STEP_WAIT: begin
                if (run_s) begin
                    state_next   = RUN;
                    div_cnt_next = '0;
                end else if (!db_lvl_reg) begin
                    state_next = HALT;
                end
            end
            RUN: begin
                if (!run_s) begin
                    state_next   = HALT;
                    div_cnt_next = '0;
                end else if (div_cnt_reg >= div_ratio) begin
                    // >= so a ratio lowered mid-count fires at once instead of wrapping
                    cpu_ce_next  = 1'b1;
                    div_cnt_next = '0;
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next   = HALT;
                div_cnt_next = '0;
            end
        endcase
    end

    assign cpu_ce     = cpu_ce_reg;
    assign halted     = halted_reg;
    assign step_count = step_count_reg;

`ifdef CLK_STEP_CLKOUT_EN
    logic cpu_clk_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_clk_reg <= 1'b0;
        end else if (cpu_ce_reg) begin
            cpu_clk_reg <= ~cpu_clk_reg;
        end
    end

    assign cpu_clk = cpu_clk_reg;
`endif

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed + randomized bench for clk_step_ctrl against a cycle-level behavioural model.
module tb_clk_step_ctrl;

    localparam int DIV_W = 8;
    localparam int DB    = 4;
    localparam int CNT_W = 16;

    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_WAIT = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             run_mode = 1'b0;
    logic             step_btn = 1'b0;
    logic [DIV_W-1:0] div_ratio = '0;
    logic             cpu_ce;
    logic             halted;
    logic [CNT_W-1:0] step_count;
`ifdef CLK_STEP_CLKOUT_EN
    logic             cpu_clk;
    logic             m_clk;
`endif

    always #5 clk = ~clk;

    clk_step_ctrl #(
        .DIV_W    (DIV_W),
        .DB_CYCLES(DB),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run_mode  (run_mode),
        .step_btn  (step_btn),
        .div_ratio (div_ratio),
        .cpu_ce    (cpu_ce),
        .halted    (halted),
        .step_count(step_count)
`ifdef CLK_STEP_CLKOUT_EN
        ,
        .cpu_clk   (cpu_clk)
`endif
    );

    // Reference model: inputs seen two edges late, a level that follows the
    // button after DB disagreeing samples, and a mode with elapsed-cycle timing.
    logic [1:0]       run_hist, btn_hist;
    logic             m_lvl, m_lvl_prev, m_ce, m_halted;
    int               m_mode, m_elapsed, m_disagree;
    logic [CNT_W-1:0] m_count;

    int vectors = 0;
    int miscompares = 0;
    int pulse_cnt = 0;

    task automatic model_reset();
        run_hist   = '0;
        btn_hist   = '0;
        m_lvl      = 1'b0;
        m_lvl_prev = 1'b0;
        m_ce       = 1'b0;
        m_halted   = 1'b1;
        m_mode     = M_HALT;
        m_elapsed  = 0;
        m_disagree = 0;
        m_count    = '0;
`ifdef CLK_STEP_CLKOUT_EN
        m_clk      = 1'b0;
`endif
    endtask

    task automatic model_step();
        logic run_seen, btn_seen, press, new_ce;
        int   new_mode, new_elapsed;
        run_seen    = run_hist[1];
        btn_seen    = btn_hist[1];
        press       = m_lvl & ~m_lvl_prev;
        new_ce      = 1'b0;
        new_mode    = m_mode;
        new_elapsed = m_elapsed;
        if (m_mode == M_HALT) begin
            if (run_seen) begin
                new_mode    = M_RUN;
                new_elapsed = 0;
            end else if (press) begin
                new_ce   = 1'b1;
                new_mode = M_WAIT;
            end
        end else if (m_mode == M_WAIT) begin
            if (run_seen) begin
                new_mode    = M_RUN;
                new_elapsed = 0;
            end else if (!m_lvl) begin
                new_mode = M_HALT;
            end
        end else begin
            if (!run_seen) begin
                new_mode    = M_HALT;
                new_elapsed = 0;
            end else if (m_elapsed + 1 > int'(div_ratio)) begin
                // period of div_ratio+1 cycles has completed
                new_ce      = 1'b1;
                new_elapsed = 0;
            end else begin
                new_elapsed = m_elapsed + 1;
            end
        end
        if (m_ce) begin
            m_count = m_count + 1'b1;
`ifdef CLK_STEP_CLKOUT_EN
            m_clk = ~m_clk;
`endif
        end
        m_lvl_prev = m_lvl;
        if (btn_seen != m_lvl) begin
            m_disagree = m_disagree + 1;
            if (m_disagree == DB) begin
                m_lvl      = btn_seen;
                m_disagree = 0;
            end
        end else begin
            m_disagree = 0;
        end
        run_hist  = {run_hist[0], run_mode};
        btn_hist  = {btn_hist[0], step_btn};
        m_ce      = new_ce;
        m_mode    = new_mode;
        m_elapsed = new_elapsed;
        m_halted  = (new_mode == M_HALT);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("cpu_ce", 32'(cpu_ce), 32'(m_ce));
        check("halted", 32'(halted), 32'(m_halted));
        check("step_count", 32'(step_count), 32'(m_count));
`ifdef CLK_STEP_CLKOUT_EN
        check("cpu_clk", 32'(cpu_clk), 32'(m_clk));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        else model_reset();
        #1;
        if (cpu_ce === 1'b1) pulse_cnt++;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int               lat;
        int               guard;
        logic [CNT_W-1:0] cnt_before;

        model_reset();

        // Reset hold with inputs thrashing
        for (int i = 0; i < 8; i++) begin
            run_mode  = 1'($urandom);
            step_btn  = 1'($urandom);
            div_ratio = DIV_W'($urandom);
            tick();
        end
        run_mode  = 1'b0;
        step_btn  = 1'b0;
        div_ratio = '0;
        tick();
        rst = 1'b1;
        ticks(4);
        check("halted_after_release", 32'(halted), 32'd1);

        // Free-run at ratio 3 and ratio 0
        div_ratio = 8'd3;
        run_mode  = 1'b1;
        ticks(10);
        pulse_cnt = 0;
        ticks(20);
        check("run_div3_pulses", 32'(pulse_cnt), 32'd5);
        div_ratio = 8'd0;
        ticks(2);
        pulse_cnt = 0;
        ticks(10);
        check("run_div0_pulses", 32'(pulse_cnt), 32'd10);

        for (int r = 0; r < 4; r++) begin
            div_ratio = DIV_W'($urandom_range(0, 12));
            ticks(40);
        end

        // Ratio shrink mid-count
        div_ratio = 8'd200;
        ticks(110);
        pulse_cnt = 0;
        div_ratio = 8'd5;
        tick();
        check("shrink_immediate_pulse", 32'(cpu_ce), 32'd1);
        pulse_cnt = 0;
        ticks(18);
        check("shrink_period6_pulses", 32'(pulse_cnt), 32'd3);

        // Bounce rejection in halt
        run_mode = 1'b0;
        ticks(6);
        pulse_cnt = 0;
        for (int b = 0; b < 5; b++) begin
            step_btn = 1'b1;
            ticks($urandom_range(1, 3));
            step_btn = 1'b0;
            ticks($urandom_range(1, 4));
        end
        ticks(10);
        check("bounce_no_pulse", 32'(pulse_cnt), 32'd0);

        // Clean press held 40 cycles
        cnt_before = m_count;
        pulse_cnt  = 0;
        lat        = -1;
        step_btn   = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (cpu_ce === 1'b1 && lat < 0) lat = i;
        end
        check("press_pulse_count", 32'(pulse_cnt), 32'd1);
        check("press_latency", 32'(lat), 32'd7);
        check("press_step_count", 32'(step_count), 32'(cnt_before + 1'b1));
        step_btn = 1'b0;
        ticks(12);

        // Random press/release trains in halt
        for (int p = 0; p < 8; p++) begin
            step_btn = 1'b1;
            ticks($urandom_range(1, 12));
            step_btn = 1'b0;
            ticks($urandom_range(1, 12));
        end
        ticks(12);

        // Mode switch mid-count, then a press while running
        div_ratio = 8'd4;
        run_mode  = 1'b1;
        ticks(13);
        run_mode = 1'b0;
        ticks(3);
        check("halt_within_3", 32'(halted), 32'd1);
        pulse_cnt = 0;
        ticks(10);
        check("halt_no_pulse", 32'(pulse_cnt), 32'd0);
        run_mode = 1'b1;
        ticks(8);
        step_btn = 1'b1;
        ticks(20);
        step_btn = 1'b0;
        ticks(10);

        // Random mixed stimulus
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 15) == 0) run_mode = ~run_mode;
            if ($urandom_range(0, 3) == 0) step_btn = 1'($urandom);
            if ($urandom_range(0, 31) == 0) div_ratio = DIV_W'($urandom_range(0, 9));
            tick();
        end

        // Mid-operation reset aborting a pulse
        step_btn  = 1'b0;
        run_mode  = 1'b1;
        div_ratio = 8'd2;
        ticks(10);
        guard = 0;
        while (m_ce !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        check("ce_before_reset", 32'(cpu_ce), 32'd1);
        rst = 1'b0;
        #1;
        model_reset();
        check("reset_async_ce", 32'(cpu_ce), 32'd0);
        check("reset_async_halted", 32'(halted), 32'd1);
        check("reset_async_count", 32'(step_count), 32'd0);
`ifdef CLK_STEP_CLKOUT_EN
        check("reset_async_clk", 32'(cpu_clk), 32'd0);
`endif
        ticks(3);
        run_mode = 1'b0;
        tick();
        rst = 1'b1;
        ticks(5);
        check("post_reset_halted", 32'(halted), 32'd1);
        check("post_reset_count", 32'(step_count), 32'd0);

        // Button held across reset release counts as a fresh press
        rst      = 1'b0;
        step_btn = 1'b1;
        tick();
        rst       = 1'b1;
        pulse_cnt = 0;
        ticks(14);
        check("held_btn_after_reset", 32'(pulse_cnt), 32'd1);
        step_btn = 1'b0;
        ticks(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
